// File: rtl/key_sched_ctrl_pkg.sv
// Shared constants, FSM encoding and index helpers for the round-key scheduler.
package key_sched_ctrl_pkg;

    localparam int NR_DEF      = 10;
    localparam int KW_DEF      = 128;
    localparam int TIMEOUT_DEF = 64;
    localparam int RIW         = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } ks_state_e;

    // Decrypt walks the schedule backwards: logical index idx maps to slot nr-idx.
    function automatic logic [RIW-1:0] mirror_idx(input logic [RIW-1:0] idx,
                                                  input logic [RIW-1:0] nr);
        return nr - idx;
    endfunction

endpackage

// File: rtl/key_sched_ctrl_rk_store.sv
// Round-key register file: one write port, one registered read port.
module key_sched_ctrl_rk_store #(
    parameter int NR = 10,
    parameter int KW = 128,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [KW-1:0] wr_data,
    input  logic          re,
    input  logic [AW-1:0] rd_addr,
    output logic [KW-1:0] rd_data
);

    logic [KW-1:0] mem [NR+1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Only the output register is reset; rd_data holds between accepted reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (re) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/key_sched_ctrl.sv
// Drives top_keyexp one round at a time, stores rounds 0..NR and serves
// round-key reads with optional mirrored indexing for decrypt.
//
// state   | meaning
// IDLE    | no expansion running (after reset or timeout abort)
// REQ     | one-cycle ke_start pulse for round r
// WAIT    | waiting for ke_ready; timeout counter running
// DONE    | all NR+1 keys stored, keys_ready high
module key_sched_ctrl
    import key_sched_ctrl_pkg::*;
#(
    parameter int NR      = NR_DEF,
    parameter int KW      = KW_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [KW-1:0]  key_in,
    input  logic           key_load,
    input  logic           en_de,
    output logic           busy,
    output logic           keys_ready,
    output logic           ke_err,
    input  logic           rk_req,
    input  logic [RIW-1:0] rk_idx,
    output logic [KW-1:0]  rk_out,
    output logic           rk_valid,
    output logic [KW-1:0]  ke_key,
    output logic           ke_start,
    output logic           ke_en_de,
    output logic [RIW-1:0] ke_round,
    input  logic [KW-1:0]  ke_key_out,
    input  logic           ke_ready
);

    localparam int             CW       = $clog2(TIMEOUT);
    localparam logic [RIW-1:0] NR_L     = RIW'(NR);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

    ks_state_e      state, state_nxt;
    logic [RIW-1:0] r;
    logic [CW-1:0]  cnt;
    logic [KW-1:0]  prev_key;
    logic           ready_hit, timeout_hit, rd_ok;
    logic [RIW-1:0] phys_idx;

    assign ready_hit   = (state == ST_WAIT) && ke_ready && !key_load;
    assign timeout_hit = (state == ST_WAIT) && !ke_ready && !key_load && (cnt == CNT_LAST);

    always_comb begin
        state_nxt = state;
        if (key_load) begin
            state_nxt = ST_REQ;
        end else begin
            case (state)
                ST_REQ:  state_nxt = ST_WAIT;
                ST_WAIT: begin
                    if (ke_ready) begin
                        state_nxt = (r == NR_L) ? ST_DONE : ST_REQ;
                    end else if (cnt == CNT_LAST) begin
                        state_nxt = ST_IDLE;
                    end
                end
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // prev_key always holds slot[r-1], so the request key needs no store read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r          <= '0;
            cnt        <= '0;
            prev_key   <= '0;
            busy       <= 1'b0;
            keys_ready <= 1'b0;
            ke_err     <= 1'b0;
            rk_valid   <= 1'b0;
        end else begin
            rk_valid <= rd_ok;
            if (key_load) begin
                r          <= RIW'(1);
                prev_key   <= key_in;
                keys_ready <= 1'b0;
                ke_err     <= 1'b0;
                busy       <= 1'b1;
            end else begin
                if (state == ST_REQ) begin
                    cnt <= '0;
                end else if (state == ST_WAIT) begin
                    cnt <= cnt + 1'b1;
                end
                if (ready_hit) begin
                    prev_key <= ke_key_out;
                    if (r == NR_L) begin
                        busy       <= 1'b0;
                        keys_ready <= 1'b1;
                    end else begin
                        r <= r + 1'b1;
                    end
                end
                if (timeout_hit) begin
                    ke_err <= 1'b1;
                    busy   <= 1'b0;
                end
            end
        end
    end

    assign ke_start = (state == ST_REQ);
    assign ke_en_de = 1'b1;
    assign ke_round = r;
    assign ke_key   = prev_key;

    assign rd_ok    = rk_req && keys_ready && (rk_idx <= NR_L);
    assign phys_idx = en_de ? rk_idx : mirror_idx(rk_idx, NR_L);

    key_sched_ctrl_rk_store #(
        .NR (NR),
        .KW (KW),
        .AW (RIW)
    ) u_store (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (key_load || ready_hit),
        .wr_addr (key_load ? '0 : r),
        .wr_data (key_load ? key_in : ke_key_out),
        .re      (rd_ok),
        .rd_addr (phys_idx),
        .rd_data (rk_out)
    );

endmodule

// File: tb/tb_key_sched_ctrl.sv
// Bench for key_sched_ctrl: behavioural top_keyexp responder, AES-128 key-expansion
// reference model and a read scoreboard drained by an independent monitor.
module tb_key_sched_ctrl;

    localparam int NR      = 10;
    localparam int KW      = 128;
    localparam int TIMEOUT = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [KW-1:0] key_in = '0;
    logic          key_load = 1'b0;
    logic          en_de = 1'b1;
    logic          busy, keys_ready, ke_err;
    logic          rk_req = 1'b0;
    logic [3:0]    rk_idx = '0;
    logic [KW-1:0] rk_out;
    logic          rk_valid;
    logic [KW-1:0] ke_key;
    logic          ke_start, ke_en_de;
    logic [3:0]    ke_round;
    logic [KW-1:0] ke_key_out;
    logic          ke_ready;

    always #5 clk = ~clk;

    key_sched_ctrl #(.NR(NR), .KW(KW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_load(key_load), .en_de(en_de),
        .busy(busy), .keys_ready(keys_ready), .ke_err(ke_err), .rk_req(rk_req),
        .rk_idx(rk_idx), .rk_out(rk_out), .rk_valid(rk_valid), .ke_key(ke_key),
        .ke_start(ke_start), .ke_en_de(ke_en_de), .ke_round(ke_round),
        .ke_key_out(ke_key_out), .ke_ready(ke_ready)
    );

    int            n_checks = 0;
    int            n_fail   = 0;
    int            n_pops   = 0;
    logic [KW-1:0] exp_q[$];
    logic [KW-1:0] exp_keys[0:NR];
    bit            model_ready = 0;
    int            rounds_seen[$];
    bit            silent = 0;
    int            hold_round = 0;
    bit            stale_now = 0;

    task automatic check(input string name, input logic [KW-1:0] act, input logic [KW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic checkb(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic checkn(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- AES-128 arithmetic ----------------
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = xtime(aa);
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    // S-box from its definition: GF(2^8) inverse (x^254) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Single-step expansion, as the top_keyexp stand-in computes it.
    function automatic logic [KW-1:0] next_rk(input logic [KW-1:0] k, input logic [3:0] rd);
        logic [31:0] t, n0, n1, n2, n3;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 1; i < int'(rd); i++) rc = xtime(rc);
        t  = sub_word({k[23:0], k[31:24]}) ^ {rc, 24'h0};
        n0 = k[127:96] ^ t;
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // Reference schedule: the FIPS-197 word recurrence w[i] = w[i-4] ^ f(w[i-1]).
    task automatic set_model(input logic [KW-1:0] k);
        logic [31:0] w[0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int rr = 0; rr <= NR; rr++) exp_keys[rr] = {w[4*rr], w[4*rr+1], w[4*rr+2], w[4*rr+3]};
    endtask

    // ---------------- top_keyexp stand-in ----------------
    initial begin : keyexp_model
        int            resp_cnt;
        bit            resp_pend;
        logic [KW-1:0] resp_data;
        int            stale_cnt;
        resp_cnt = 0; resp_pend = 0; resp_data = '0; stale_cnt = 0;
        ke_ready = 1'b0;
        ke_key_out = '0;
        forever begin
            @(negedge clk);
            if (rst_n && ke_start) begin
                rounds_seen.push_back(int'(ke_round));
                resp_pend = !silent && (int'(ke_round) != hold_round);
                resp_cnt  = $urandom_range(1, 3);
                resp_data = next_rk(ke_key, ke_round);
            end
            @(posedge clk);
            #1;
            ke_ready = 1'b0;
            if (stale_now) begin
                stale_now = 0;
                stale_cnt = 2;
            end
            if (stale_cnt > 0) begin
                ke_ready   = 1'b1;
                ke_key_out = ~resp_data;
                stale_cnt--;
            end else if (resp_pend) begin
                resp_cnt--;
                if (resp_cnt == 0) begin
                    ke_ready   = 1'b1;
                    ke_key_out = resp_data;
                    resp_pend  = 0;
                end
            end
        end
    end

    // ---------------- read monitor ----------------
    initial begin : monitor
        logic [KW-1:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && rk_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rk_unexpected: rk_valid=1 with nothing outstanding, rk_out=%h", rk_out);
                end else begin
                    e = exp_q.pop_front();
                    n_pops++;
                    check("rk_out", rk_out, e);
                end
            end
        end
    end

    initial begin : watchdog
        #500_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_exp(input int idx, input bit ende, input logic [KW-1:0] e);
        rk_req = 1'b1; rk_idx = 4'(idx); en_de = ende;
        exp_q.push_back(e);
        tick();
        rk_req = 1'b0;
    endtask

    task automatic do_read(input int idx, input bit ende);
        rk_req = 1'b1; rk_idx = 4'(idx); en_de = ende;
        if (model_ready && idx <= NR) exp_q.push_back(exp_keys[ende ? idx : NR - idx]);
        tick();
        rk_req = 1'b0;
    endtask

    task automatic load_key(input logic [KW-1:0] k);
        key_in = k; key_load = 1'b1;
        tick();
        key_load = 1'b0;
        model_ready = 0;
        set_model(k);
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!keys_ready && n < 2000);
        checkb({tag, "_keys_ready"}, keys_ready, 1'b1);
        checkb({tag, "_busy_done"}, busy, 1'b0);
        tick();
        model_ready = 1;
    endtask

    task automatic check_rounds(input string tag);
        checkn({tag, "_nstart"}, rounds_seen.size(), NR);
        for (int i = 0; i < rounds_seen.size() && i < NR; i++)
            checkn({tag, "_round_order"}, rounds_seen[i], i + 1);
    endtask

    function automatic logic [KW-1:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic random_reads(input int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) tick();
            do_read($urandom_range(0, 15), 1'($urandom_range(0, 1)));
        end
    endtask

    // ---------------- main sequence ----------------
    localparam logic [KW-1:0] K_FIPS  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [KW-1:0] RK1     = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [KW-1:0] RK10    = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    initial begin : stim
        logic [KW-1:0] held, k_old;
        int            n, m, pops0, seen0;

        #12;
        checkb("rst_busy", busy, 1'b0);
        checkb("rst_keys_ready", keys_ready, 1'b0);
        checkb("rst_ke_err", ke_err, 1'b0);
        checkb("rst_ke_start", ke_start, 1'b0);
        checkb("rst_rk_valid", rk_valid, 1'b0);
        checkn("rst_ke_round", int'(ke_round), 0);
        check("rst_ke_key", ke_key, '0);
        check("rst_rk_out", rk_out, '0);
        checkb("ke_en_de_tied", ke_en_de, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Reads before any expansion are refused.
        do_read(3, 1'b1);
        tick();
        checkb("early_rd_valid", rk_valid, 1'b0);
        check("early_rd_hold", rk_out, '0);

        // FIPS-197 key, checked against published round keys.
        rounds_seen.delete();
        load_key(K_FIPS);
        checkb("busy_running", busy, 1'b1);
        do_read(0, 1'b1);
        wait_ready("fips");
        check_rounds("fips");
        read_exp(1, 1'b1, RK1);
        read_exp(10, 1'b1, RK10);
        read_exp(0, 1'b0, RK10);
        read_exp(10, 1'b0, K_FIPS);
        tick();
        pops0 = n_pops;
        for (int i = 0; i <= NR; i++) do_read(i, 1'b0);
        tick();
        checkn("b2b_pulses", n_pops - pops0, NR + 1);
        random_reads(40);
        tick(); tick();
        held = rk_out;
        do_read(11, 1'b1);
        do_read(15, 1'b0);
        tick();
        checkb("oob_rd_valid", rk_valid, 1'b0);
        check("oob_rd_hold", rk_out, held);

        // Read in the key_load cycle is served from the old store.
        k_old = exp_keys[0];
        rounds_seen.delete();
        key_in = rand_key(); key_load = 1'b1;
        read_exp(0, 1'b1, k_old);
        key_load = 1'b0;
        model_ready = 0;
        set_model(key_in);
        wait_ready("second");
        check_rounds("second");
        random_reads(20);

        // Abort after round 4 stored; stale ke_ready lands with key_load and in REQ.
        hold_round = 5;
        rounds_seen.delete();
        load_key(rand_key());
        n = 0;
        do begin @(negedge clk); n++; end while (rounds_seen.size() < 5 && n < 500);
        checkn("abort_reached_r5", rounds_seen.size(), 5);
        stale_now = 1;
        tick();
        rounds_seen.delete();
        hold_round = 0;
        load_key(rand_key());
        wait_ready("abort");
        check_rounds("abort");
        for (int i = 0; i <= NR; i++) do_read(i, 1'b1);

        // Silent keyexp: timeout. ke_start is sampled by keyexp at edge E0; ke_err is
        // set at edge E0+TIMEOUT and so first seen TIMEOUT+1 falling edges after ke_start.
        tick();
        silent = 1;
        rounds_seen.delete();
        load_key(rand_key());
        n = 0;
        do begin @(negedge clk); n++; end while (!ke_start && n < 20);
        checkb("to_start_seen", ke_start, 1'b1);
        m = 0;
        do begin @(negedge clk); m++; end while (!ke_err && m < 200);
        checkn("to_latency", m, TIMEOUT + 1);
        checkb("to_busy", busy, 1'b0);
        checkb("to_keys_ready", keys_ready, 1'b0);
        repeat (10) @(negedge clk);
        checkb("to_err_sticky", ke_err, 1'b1);
        checkn("to_single_start", rounds_seen.size(), 1);
        tick();
        do_read(2, 1'b1);
        tick();
        checkb("to_rd_refused", rk_valid, 1'b0);
        silent = 0;
        rounds_seen.delete();
        load_key(rand_key());
        checkb("err_cleared", ke_err, 1'b0);
        wait_ready("recover");
        check_rounds("recover");
        for (int i = 0; i <= NR; i++) do_read(i, 1'b0);
        tick(); tick();

        // Async reset mid-cycle while in WAIT.
        silent = 1;
        load_key(rand_key());
        n = 0;
        do begin @(negedge clk); n++; end while (!ke_start && n < 20);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkb("arst_busy", busy, 1'b0);
        checkb("arst_keys_ready", keys_ready, 1'b0);
        checkb("arst_ke_err", ke_err, 1'b0);
        checkb("arst_ke_start", ke_start, 1'b0);
        checkb("arst_rk_valid", rk_valid, 1'b0);
        checkn("arst_ke_round", int'(ke_round), 0);
        check("arst_ke_key", ke_key, '0);
        check("arst_rk_out", rk_out, '0);
        @(negedge clk);
        rst_n = 1'b1;
        model_ready = 0;
        seen0 = rounds_seen.size();
        repeat (20) @(negedge clk);
        checkn("arst_no_start", rounds_seen.size(), seen0);
        silent = 0;
        tick();
        rounds_seen.delete();
        load_key(rand_key());
        wait_ready("post_rst");
        check_rounds("post_rst");
        random_reads(15);

        repeat (3) tick();
        checkn("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
